instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage that sits directly downstream of the program counter register and upstream of decode. It consumes the current `pc`, issues one instruction-memory request at a time, buffers returned instructions in a 2-entry queue, and drives `next_pc`/`pc_en` back into the program counter. Branch/jump redirects from execute flush the stage, and any in-flight memory response is discarded.

## Interface
- No parameters; depth fixed at 2, width 32.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- pc  in  32  current PC from the program counter register (resets to 0)
- next_pc  out  32  value loaded into the PC when pc_en=1
- pc_en  out  1  PC update strobe
- imem_req_valid  out  1  memory request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  request address (= pc)
- imem_rsp_valid  in  1  response valid, single-cycle pulse, no backpressure
- imem_rsp_data  in  32  response instruction word
- redirect_valid  in  1  control-flow redirect from execute
- redirect_pc  in  32  redirect target
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts instruction
- if_instr  out  32  instruction word at queue head
- if_pc  out  32  PC of that instruction

## Operation
- FSM states: FETCH, WAIT, DRAIN. Reset state FETCH.
- Queue: 2 entries of {pc, instr}. `occ` = entries held; `out` = 1 in WAIT, 0 otherwise.
- FETCH: imem_req_valid = (occ + out < 2) && !redirect_valid. On accept (valid && ready): pc_en=1, next_pc=pc+4, latch req_pc=pc, go WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid: push {req_pc, imem_rsp_data}, go FETCH.
- DRAIN: imem_req_valid=0. On imem_rsp_valid: discard data, go FETCH.
- Redirect (any state, priority over everything): pc_en=1, next_pc={redirect_pc[31:2],2'b00}; queue flushed (occ=0; same-cycle pop and push are cancelled).
  - In FETCH: no request issued this cycle; stay FETCH.
  - In WAIT without rsp this cycle: go DRAIN. With rsp this cycle: drop response, go FETCH.
  - In DRAIN without rsp this cycle: stay DRAIN. With rsp this cycle: drop response, go FETCH.
- pc_en=0 in all other cycles; next_pc is don't-care when pc_en=0.
- imem_rsp_valid in FETCH is ignored.
- Pop: if_valid && if_ready removes the head. Push and pop in the same cycle are both legal.
- PC arithmetic: pc+4 is modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Output is in-order. if_instr/if_pc are 0 when the queue is empty.

## Timing
- Reset (async): state FETCH, occ=0, if_valid=0, if_instr=0, if_pc=0, imem_req_valid=0, pc_en=0, req_pc=0.
- Memory returns data no earlier than 1 cycle after accept.
- Request accepted in cycle N: PC shows pc+4 in N+1. Response arriving in cycle M makes if_valid=1 in M+1, and the next request can be issued in M+1.
- Zero-wait memory gives throughput of 1 instruction per 2 cycles.
- Redirect in cycle N: PC equals target in N+1, if_valid=0 in N+1, and the first request to the target is issued in N+1 (from FETCH) or after the drain response.
- imem_req_valid may drop only on redirect or state change. imem_req_addr is stable while valid && !ready.
- Reset asserted mid-WAIT: any later stale response is ignored because the state is FETCH.

## Test plan
- Reset then zero-wait memory returning addr^0xA5A5_0000, if_ready=1 -> if_pc sequence 0,4,8,12 with matching instr; pc_en pulses once per request.
- Memory with 3-cycle response latency and imem_req_ready stalled 2 cycles -> imem_req_addr held at 0 while stalled; if_valid 1 cycle after each response; no duplicated or skipped PC.
- if_ready=0 for 10 cycles -> queue fills with PCs 0 and 4, then imem_req_valid stays 0 and pc holds at 8; releasing if_ready drains 0,4 in order, then fetch resumes at 8.
- Redirect to 0x103 while in WAIT, response 2 cycles later -> next_pc=0x100, old response discarded, first if_pc after redirect = 0x100.
- Redirect in the same cycle as imem_rsp_valid with a full queue and if_ready=1 -> queue empty next cycle, nothing popped or pushed, state FETCH.
- pc=0xFFFF_FFFC fetch -> next_pc=0x0000_0000; assert async reset in WAIT -> all outputs at reset values immediately, late response ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one imem request at a time, buffers responses in a
// 2-entry in-order queue for decode, and handles execute redirects by flushing.
module instr_fetch (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] next_pc,
   output logic        pc_en,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

   state_t      state;
   logic [1:0]  occ;
   logic        head;
   logic [31:0] q_pc    [2];
   logic [31:0] q_instr [2];
   logic [31:0] req_pc;

   logic        in_flight;
   logic [2:0]  committed;
   logic        accept;
   logic        push;
   logic        pop;
   logic        tail;

   assign imem_req_addr = pc;
   assign if_valid      = (occ != 2'd0);
   assign if_instr      = if_valid ? q_instr[head] : 32'd0;
   assign if_pc         = if_valid ? q_pc[head]    : 32'd0;

   // Handshake outputs must react in the same cycle as ready/redirect, so they stay
   // combinational; the request only goes out when a free slot is guaranteed.
   always_comb begin
      in_flight      = (state == WAIT);
      committed      = {1'b0, occ} + {2'b00, in_flight};
      imem_req_valid = !reset && (state == FETCH) && (committed < 3'd2) && !redirect_valid;
      accept         = imem_req_valid && imem_req_ready;
      pc_en          = !reset && (redirect_valid || accept);
      next_pc        = redirect_valid ? (redirect_pc & ~32'd3) : (pc + 32'd4);
      push           = !redirect_valid && (state == WAIT) && imem_rsp_valid;
      pop            = !redirect_valid && if_valid && if_ready;
      tail           = head ^ occ[0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ  <= 2'd0;
         head <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            q_pc[i]    <= 32'd0;
            q_instr[i] <= 32'd0;
         end
      end else if (redirect_valid) begin
         occ <= 2'd0;
      end else begin
         if (push) begin
            q_pc[tail]    <= req_pc;
            q_instr[tail] <= imem_rsp_data;
         end
         if (pop)
            head <= ~head;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   // A redirect while a request is outstanding must still swallow its response,
   // which is what DRAIN is for.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= FETCH;
         req_pc <= 32'd0;
      end else begin
         case (state)
            FETCH: begin
               if (accept) begin
                  req_pc <= pc;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (redirect_valid)
                  state <= imem_rsp_valid ? FETCH : DRAIN;
               else if (imem_rsp_valid)
                  state <= FETCH;
            end
            DRAIN: begin
               if (imem_rsp_valid)
                  state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch; the bench models the PC register and a simple
// instruction memory that answers with addr ^ 0xA5A5_0000.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        pc_en;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   int checks = 0;
   int errors = 0;

   int          cyc;
   logic [15:0] pcen_mask;
   logic [31:0] pop_pc    [$];
   logic [31:0] pop_instr [$];
   int          pop_cyc   [$];

   logic        mem_auto;
   int          mem_lat;
   logic        mem_pend;
   int          mem_cnt;
   logic [31:0] mem_addr;

   instr_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .pc             (pc),
      .next_pc        (next_pc),
      .pc_en          (pc_en),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Runs one clock cycle: samples at the falling edge, then updates the PC model and
   // the auto-responding memory just after the rising edge.
   task automatic cycle();
      logic        acc;
      logic [31:0] acc_addr;
      logic        en;
      logic [31:0] npc;
      @(negedge clk);
      acc      = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      en       = pc_en;
      npc      = next_pc;
      if (cyc < 16) pcen_mask[cyc] = en;
      if (if_valid && if_ready) begin
         pop_pc.push_back(if_pc);
         pop_instr.push_back(if_instr);
         pop_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (reset) pc = 32'd0;
      else if (en) pc = npc;
      cyc++;
      if (mem_auto) begin
         imem_rsp_valid = 1'b0;
         if (acc) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = acc_addr;
         end
         if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_addr ^ 32'hA5A5_0000;
               mem_pend       = 1'b0;
            end
         end
      end
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      pc             = 32'd0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      if_ready       = 1'b0;
      mem_auto       = 1'b0;
      mem_lat        = 1;
      mem_pend       = 1'b0;
      mem_cnt        = 0;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      cyc       = 0;
      pcen_mask = '0;
      pop_pc.delete();
      pop_instr.delete();
      pop_cyc.delete();
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      #2;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
      checks++; if (pc_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_en: got %b expected 0", pc_en); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_if_valid: got %b expected 0", if_valid); end
      checks++; if (if_instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_if_instr: got %h expected 0", if_instr); end
      checks++; if (if_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_if_pc: got %h expected 0", if_pc); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_req_valid: got %b expected 1", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'd0) begin errors++; $display("[TB] FAIL post_reset_req_addr: got %h expected 0", imem_req_addr); end
   endtask

   task automatic test_zero_wait();
      do_reset();
      mem_auto       = 1'b1;
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      repeat (9) cycle();
      checks++; if (pcen_mask[8:0] !== 9'h155) begin errors++; $display("[TB] FAIL zw_pc_en_pattern: got %h expected 155", pcen_mask[8:0]); end
      checks++; if (pop_pc.size() != 4) begin errors++; $display("[TB] FAIL zw_pop_count: got %0d expected 4", pop_pc.size()); end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] gp, gi;
         int          gc;
         gp = (i < pop_pc.size()) ? pop_pc[i]    : 32'hxxxx_xxxx;
         gi = (i < pop_pc.size()) ? pop_instr[i] : 32'hxxxx_xxxx;
         gc = (i < pop_pc.size()) ? pop_cyc[i]   : -1;
         checks++; if (gp !== 32'(4 * i)) begin errors++; $display("[TB] FAIL zw_pc[%0d]: got %h expected %h", i, gp, 32'(4 * i)); end
         checks++; if (gi !== (32'(4 * i) ^ 32'hA5A5_0000)) begin errors++; $display("[TB] FAIL zw_instr[%0d]: got %h expected %h", i, gi, 32'(4 * i) ^ 32'hA5A5_0000); end
         checks++; if (gc != 2 + 2 * i) begin errors++; $display("[TB] FAIL zw_cycle[%0d]: got %0d expected %0d", i, gc, 2 + 2 * i); end
      end
   endtask

   task automatic test_stall_latency();
      do_reset();
      mem_auto = 1'b1;
      mem_lat  = 3;
      if_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         imem_req_ready = 1'b0;
         #1;
         checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", i, imem_req_valid); end
         checks++; if (imem_req_addr !== 32'd0) begin errors++; $display("[TB] FAIL stall_addr[%0d]: got %h expected 0", i, imem_req_addr); end
         cycle();
      end
      imem_req_ready = 1'b1;
      repeat (9) cycle();
      checks++; if (pop_pc.size() != 2) begin errors++; $display("[TB] FAIL lat_pop_count: got %0d expected 2", pop_pc.size()); end
      for (int i = 0; i < 2; i++) begin
         logic [31:0] gp, gi;
         int          gc;
         gp = (i < pop_pc.size()) ? pop_pc[i]    : 32'hxxxx_xxxx;
         gi = (i < pop_pc.size()) ? pop_instr[i] : 32'hxxxx_xxxx;
         gc = (i < pop_pc.size()) ? pop_cyc[i]   : -1;
         checks++; if (gp !== 32'(4 * i)) begin errors++; $display("[TB] FAIL lat_pc[%0d]: got %h expected %h", i, gp, 32'(4 * i)); end
         checks++; if (gi !== (32'(4 * i) ^ 32'hA5A5_0000)) begin errors++; $display("[TB] FAIL lat_instr[%0d]: got %h expected %h", i, gi, 32'(4 * i) ^ 32'hA5A5_0000); end
         checks++; if (gc != 6 + 4 * i) begin errors++; $display("[TB] FAIL lat_cycle[%0d]: got %0d expected %0d", i, gc, 6 + 4 * i); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      mem_auto       = 1'b1;
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      if_ready       = 1'b0;
      repeat (10) cycle();
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
      checks++; if (pc !== 32'd8) begin errors++; $display("[TB] FAIL bp_pc_hold: got %h expected 8", pc); end
      checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_if_valid: got %b expected 1", if_valid); end
      checks++; if (if_pc !== 32'd0) begin errors++; $display("[TB] FAIL bp_head_pc: got %h expected 0", if_pc); end
      checks++; if (if_instr !== 32'hA5A5_0000) begin errors++; $display("[TB] FAIL bp_head_instr: got %h expected a5a50000", if_instr); end
      if_ready = 1'b1;
      repeat (4) cycle();
      checks++; if (pcen_mask[11:0] !== 12'h805) begin errors++; $display("[TB] FAIL bp_pc_en_pattern: got %h expected 805", pcen_mask[11:0]); end
      checks++; if (pop_pc.size() != 3) begin errors++; $display("[TB] FAIL bp_pop_count: got %0d expected 3", pop_pc.size()); end
      for (int i = 0; i < 3; i++) begin
         logic [31:0] gp;
         int          gc;
         int          ec;
         ec = (i == 0) ? 10 : (i == 1) ? 11 : 13;
         gp = (i < pop_pc.size()) ? pop_pc[i]  : 32'hxxxx_xxxx;
         gc = (i < pop_pc.size()) ? pop_cyc[i] : -1;
         checks++; if (gp !== 32'(4 * i)) begin errors++; $display("[TB] FAIL bp_pc[%0d]: got %h expected %h", i, gp, 32'(4 * i)); end
         checks++; if (gc != ec) begin errors++; $display("[TB] FAIL bp_cycle[%0d]: got %0d expected %0d", i, gc, ec); end
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      #1;
      checks++; if (pc_en !== 1'b1) begin errors++; $display("[TB] FAIL rw_pc_en: got %b expected 1", pc_en); end
      checks++; if (next_pc !== 32'h0000_0100) begin errors++; $display("[TB] FAIL rw_next_pc: got %h expected 00000100", next_pc); end
      cycle();
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_drain_req0: got %b expected 0", imem_req_valid); end
      cycle();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_drain_req1: got %b expected 0", imem_req_valid); end
      cycle();
      imem_rsp_valid = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rw_refetch_valid: got %b expected 1", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL rw_refetch_addr: got %h expected 00000100", imem_req_addr); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_stale_dropped: got %b expected 0", if_valid); end
      cycle();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1111_1111;
      cycle();
      imem_rsp_valid = 1'b0;
      #1;
      checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL rw_new_valid: got %b expected 1", if_valid); end
      checks++; if (if_pc !== 32'h0000_0100) begin errors++; $display("[TB] FAIL rw_new_pc: got %h expected 00000100", if_pc); end
      checks++; if (if_instr !== 32'h1111_1111) begin errors++; $display("[TB] FAIL rw_new_instr: got %h expected 11111111", if_instr); end
   endtask

   task automatic test_redirect_full();
      do_reset();
      mem_auto       = 1'b1;
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      if_ready       = 1'b0;
      repeat (4) cycle();
      mem_auto = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rf_full_req: got %b expected 0", imem_req_valid); end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBADB_AD00;
      if_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      #1;
      checks++; if (pc_en !== 1'b1) begin errors++; $display("[TB] FAIL rf_pc_en: got %b expected 1", pc_en); end
      checks++; if (next_pc !== 32'h0000_0200) begin errors++; $display("[TB] FAIL rf_next_pc: got %h expected 00000200", next_pc); end
      cycle();
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rf_flushed: got %b expected 0", if_valid); end
      checks++; if (if_pc !== 32'd0) begin errors++; $display("[TB] FAIL rf_if_pc: got %h expected 0", if_pc); end
      checks++; if (if_instr !== 32'd0) begin errors++; $display("[TB] FAIL rf_if_instr: got %h expected 0", if_instr); end
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rf_fetch_state: got %b expected 1", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h0000_0200) begin errors++; $display("[TB] FAIL rf_req_addr: got %h expected 00000200", imem_req_addr); end
      cycle();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h3333_3333;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      cycle();
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rf_wait_rsp_to_fetch: got %b expected 1", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h0000_0300) begin errors++; $display("[TB] FAIL rf_wait_rsp_addr: got %h expected 00000300", imem_req_addr); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rf_wait_rsp_dropped: got %b expected 0", if_valid); end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected fffffffc", imem_req_addr); end
      checks++; if (pc_en !== 1'b1) begin errors++; $display("[TB] FAIL wrap_pc_en: got %b expected 1", pc_en); end
      checks++; if (next_pc !== 32'd0) begin errors++; $display("[TB] FAIL wrap_next_pc: got %h expected 0", next_pc); end
      cycle();
      reset = 1'b1;
      pc    = 32'd0;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_req_valid: got %b expected 0", imem_req_valid); end
      checks++; if (pc_en !== 1'b0) begin errors++; $display("[TB] FAIL async_pc_en: got %b expected 0", pc_en); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_if_valid: got %b expected 0", if_valid); end
      @(posedge clk);
      #1;
      reset          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0BAD_0BAD;
      #1;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL late_rsp_state: got %b expected 1", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'd0) begin errors++; $display("[TB] FAIL late_rsp_addr: got %h expected 0", imem_req_addr); end
      cycle();
      imem_rsp_valid = 1'b0;
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL late_rsp_ignored: got %b expected 0", if_valid); end
   endtask

   initial begin
      cyc            = 0;
      pcen_mask      = '0;
      pc             = 32'd0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      redirect_pc    = 32'd0;
      mem_auto       = 1'b0;
      mem_lat        = 1;
      mem_pend       = 1'b0;
      mem_cnt        = 0;
      mem_addr       = 32'd0;
      test_reset();
      test_zero_wait();
      test_stall_latency();
      test_backpressure();
      test_redirect_wait();
      test_redirect_full();
      test_wrap_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
